// File: rtl/bird_pkg.sv
// bird_pkg: shared game state type, colour constants and velocity width for the bird renderer
package bird_pkg;
  typedef enum logic [1:0] {IDLE, FLYING, DEAD} state_t;
  localparam int VEL_W = 8;
  localparam logic [23:0] BIRD_COLOR = 24'hFFD000;
  localparam logic [23:0] DEAD_COLOR = 24'hFF0000;
  localparam logic [23:0] SKY_COLOR  = 24'h4EC0CA;
endpackage

// File: rtl/bird_physics.sv
// bird_physics: flap sync/edge, frame tick from vs_in, game FSM and bird position/velocity; in clk_rgb rst flap vs_in, out state bird_y
module bird_physics
  import bird_pkg::*;
#(
  parameter int VER_ACTIVE_PIXELS = 720,
  parameter int BIRD_SIZE = 32,
  parameter int GRAVITY = 1,
  parameter int FLAP_VELOCITY = -12,
  parameter int MAX_FALL_VELOCITY = 16,
  parameter int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk_rgb,
  input  logic               rst,
  input  logic               flap,
  input  logic               vs_in,
  output state_t             state,
  output logic [Y_WIDTH-1:0] bird_y
);
  localparam logic signed [VEL_W-1:0] GRAV = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] FLAP_V = VEL_W'(FLAP_VELOCITY);
  localparam logic signed [VEL_W-1:0] MAX_V = VEL_W'(MAX_FALL_VELOCITY);
  localparam logic signed [Y_WIDTH+1:0] Y_MAX = (Y_WIDTH+2)'(VER_ACTIVE_PIXELS - BIRD_SIZE);
  localparam logic [Y_WIDTH-1:0] Y_CENTER = Y_WIDTH'((VER_ACTIVE_PIXELS - BIRD_SIZE) / 2);
  logic [2:0] sync_q;
  logic vs_q, pend_q;
  state_t state_q;
  logic [Y_WIDTH-1:0] pos_q;
  logic signed [VEL_W-1:0] vel_q, vel_g, vel_d;
  logic signed [Y_WIDTH+1:0] vel_x, pos_d;
  logic flap_edge, tick, flap_now, out_lo, out_hi;
  assign flap_edge = sync_q[1] & ~sync_q[2];
  assign tick = vs_in & ~vs_q;
  assign flap_now = pend_q | flap_edge;
  always_comb begin
    vel_g = vel_q + GRAV;
    vel_d = flap_now ? FLAP_V : (vel_g > MAX_V ? MAX_V : vel_g);
    vel_x = (Y_WIDTH+2)'(vel_d);
    pos_d = $signed({2'b00, pos_q}) + vel_x;
    out_lo = pos_d < 0;
    out_hi = pos_d > Y_MAX;
  end
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      sync_q <= '0;
      vs_q <= 1'b0;
      pend_q <= 1'b0;
      state_q <= IDLE;
      pos_q <= Y_CENTER;
      vel_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], flap};
      vs_q <= vs_in;
      pend_q <= !tick && flap_now;
      if (tick && (state_q == FLYING || (state_q == IDLE && flap_now))) begin
        vel_q <= vel_d;
        pos_q <= out_lo ? '0 : out_hi ? Y_WIDTH'(Y_MAX) : pos_d[Y_WIDTH-1:0];
        state_q <= (out_lo || out_hi) ? DEAD : FLYING;
      end else if (tick && state_q == DEAD && flap_now) begin
        state_q <= IDLE;
        pos_q <= Y_CENTER;
        vel_q <= '0;
      end
    end
  end
  assign state = state_q;
  assign bird_y = pos_q;
endmodule

// File: rtl/bird_renderer.sv
// bird_renderer: 2-stage bird/sky pixel pipeline with delayed syncs; in clk_rgb rst flap x y hs/vs/de_in, out r g b hs/vs/de_out state bird_y
module bird_renderer
  import bird_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 1280,
  parameter int VER_ACTIVE_PIXELS = 720,
  parameter int BIRD_X = 320,
  parameter int BIRD_SIZE = 32,
  parameter int GRAVITY = 1,
  parameter int FLAP_VELOCITY = -12,
  parameter int MAX_FALL_VELOCITY = 16,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk_rgb,
  input  logic               rst,
  input  logic               flap,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               de_in,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic               hs_out,
  output logic               vs_out,
  output logic               de_out,
  output state_t             state,
  output logic [Y_WIDTH-1:0] bird_y
);
  logic in_q, de_q, hs_q, vs_q, de2_q, hs2_q, vs2_q;
  logic [23:0] rgb_q, rgb_d;
  logic inside_d;
  bird_physics #(
    .VER_ACTIVE_PIXELS(VER_ACTIVE_PIXELS),
    .BIRD_SIZE(BIRD_SIZE),
    .GRAVITY(GRAVITY),
    .FLAP_VELOCITY(FLAP_VELOCITY),
    .MAX_FALL_VELOCITY(MAX_FALL_VELOCITY),
    .Y_WIDTH(Y_WIDTH)
  ) u_phys (
    .clk_rgb(clk_rgb),
    .rst(rst),
    .flap(flap),
    .vs_in(vs_in),
    .state(state),
    .bird_y(bird_y)
  );
  assign inside_d = de_in && x >= X_WIDTH'(BIRD_X) && x < X_WIDTH'(BIRD_X + BIRD_SIZE)
                    && y >= bird_y && {1'b0, y} < {1'b0, bird_y} + (Y_WIDTH+1)'(BIRD_SIZE);
  assign rgb_d = !de_q ? 24'h0 : !in_q ? SKY_COLOR : state == DEAD ? DEAD_COLOR : BIRD_COLOR;
  always_ff @(posedge clk_rgb) begin
    if (rst) begin
      {in_q, de_q, hs_q, vs_q, de2_q, hs2_q, vs2_q} <= '0;
      rgb_q <= '0;
    end else begin
      {in_q, de_q, hs_q, vs_q} <= {inside_d, de_in, hs_in, vs_in};
      {de2_q, hs2_q, vs2_q} <= {de_q, hs_q, vs_q};
      rgb_q <= rgb_d;
    end
  end
  assign {r, g, b} = rgb_q;
  assign {hs_out, vs_out, de_out} = {hs2_q, vs2_q, de2_q};
endmodule

// File: tb/tb_bird_renderer.sv
// tb_bird_renderer: table-driven pixel vectors plus directed physics sequences for bird_renderer
module tb_bird_renderer;
  import bird_pkg::*;
  logic clk_rgb, rst, flap, hs_in, vs_in, de_in;
  logic [10:0] x;
  logic [9:0] y;
  logic [7:0] r, g, b;
  logic hs_out, vs_out, de_out;
  state_t state;
  logic [9:0] bird_y;
  int n_cmp = 0;
  int n_bad = 0;
  state_t exp_state;
  int exp_pos, exp_vel;
  typedef struct {
    logic de, hs, vs;
    logic [10:0] x;
    logic [9:0] y;
    logic [23:0] rgb;
  } vec_t;
  vec_t vecs [9];
  bird_renderer dut (
    .clk_rgb(clk_rgb), .rst(rst), .flap(flap), .x(x), .y(y),
    .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .r(r), .g(g), .b(b), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
    .state(state), .bird_y(bird_y)
  );
  initial begin
    clk_rgb = 0;
    forever #5 clk_rgb = ~clk_rgb;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_rgb);
    #1;
  endtask
  task automatic frame();
    vs_in = 1;
    step();
    vs_in = 0;
    repeat (3) step();
  endtask
  task automatic flap_pulse();
    flap = 1;
    repeat (5) step();
    flap = 0;
    repeat (3) step();
  endtask
  task automatic pix(input string name, input int px, input int py, input logic [23:0] exp);
    de_in = 1;
    x = 11'(px);
    y = 10'(py);
    repeat (2) step();
    check(name, {r, g, b}, exp);
    de_in = 0;
  endtask
  task automatic model_tick(input bit f);
    int p;
    if (exp_state == DEAD) begin
      if (f) begin
        exp_state = IDLE;
        exp_pos = 344;
        exp_vel = 0;
      end
    end else if (exp_state == FLYING || f) begin
      exp_vel = f ? -12 : (exp_vel + 1 > 16 ? 16 : exp_vel + 1);
      p = exp_pos + exp_vel;
      exp_state = (p < 0 || p > 688) ? DEAD : FLYING;
      exp_pos = p < 0 ? 0 : (p > 688 ? 688 : p);
    end
  endtask
  task automatic check_phys(input string name);
    check({name, "_y"}, 32'(bird_y), exp_pos);
    check({name, "_st"}, 32'(state), 32'(exp_state));
  endtask
  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 11'd330, 10'd350, 24'hFFD000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 11'd100, 10'd350, 24'h4EC0CA};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 11'd330, 10'd350, 24'h000000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 11'd320, 10'd344, 24'hFFD000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 11'd351, 10'd375, 24'hFFD000};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 11'd352, 10'd350, 24'h4EC0CA};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 11'd319, 10'd350, 24'h4EC0CA};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 11'd330, 10'd343, 24'h4EC0CA};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 11'd330, 10'd376, 24'h4EC0CA};
    rst = 1; flap = 0; hs_in = 0; vs_in = 0; de_in = 0; x = 0; y = 0;
    exp_state = IDLE; exp_pos = 344; exp_vel = 0;
    repeat (3) begin
      step();
      flap = 1'($urandom); hs_in = 1'($urandom); vs_in = 1'($urandom); de_in = 1'($urandom);
      x = 11'($urandom); y = 10'($urandom);
    end
    check("rst_rgb", {r, g, b}, 0);
    check("rst_sync", {hs_out, vs_out, de_out}, 0);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_bird_y", 32'(bird_y), 344);
    flap = 0; vs_in = 0; hs_in = 1; de_in = 1; x = 330; y = 350;
    rst = 0;
    step();
    check("post_rst_rgb", {r, g, b}, 0);
    check("post_rst_sync", {hs_out, vs_out, de_out}, 0);
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) begin
        de_in = vecs[i].de; hs_in = vecs[i].hs; vs_in = vecs[i].vs; x = vecs[i].x; y = vecs[i].y;
      end else begin
        de_in = 0; hs_in = 0; vs_in = 0;
      end
      step();
      if (i > 0) begin
        check($sformatf("vec%0d_rgb", i - 1), {r, g, b}, vecs[i - 1].rgb);
        check($sformatf("vec%0d_sync", i - 1), {hs_out, vs_out, de_out},
              {vecs[i - 1].hs, vecs[i - 1].vs, vecs[i - 1].de});
      end
    end
    check("idle_still", 32'(state), 32'(IDLE));
    repeat (2) step();
    flap_pulse();
    frame();
    model_tick(1);
    check("start_y", 32'(bird_y), 332);
    check_phys("start");
    frame(); model_tick(0); check("fly1_y", 32'(bird_y), 321);
    frame(); model_tick(0); check("fly2_y", 32'(bird_y), 311);
    frame(); model_tick(0); check("fly3_y", 32'(bird_y), 302);
    check_phys("fly3");
    flap = 1;
    repeat (2) step();
    vs_in = 1;
    step();
    flap = 0;
    model_tick(1);
    check("coinc_y", 32'(bird_y), 290);
    check_phys("coinc");
    vs_in = 0;
    repeat (3) step();
    flap_pulse();
    frame(); model_tick(1); check("second_y", 32'(bird_y), 278);
    frame(); model_tick(0); check("after_second_y", 32'(bird_y), 267);
    check_phys("after_second");
    for (int k = 0; k < 80 && exp_state != DEAD; k++) begin
      frame();
      model_tick(0);
      check_phys($sformatf("fall%0d", k));
    end
    check("dead_state", 32'(state), 32'(DEAD));
    check("dead_y", 32'(bird_y), 688);
    pix("dead_pix", 330, 700, 24'hFF0000);
    pix("dead_bottom", 351, 719, 24'hFF0000);
    pix("dead_above", 330, 687, 24'h4EC0CA);
    for (int k = 0; k < 3; k++) begin
      frame();
      check($sformatf("frozen%0d_y", k), 32'(bird_y), 688);
      check($sformatf("frozen%0d_st", k), 32'(state), 32'(DEAD));
    end
    flap_pulse();
    frame();
    model_tick(1);
    check("restart_state", 32'(state), 32'(IDLE));
    check("restart_y", 32'(bird_y), 344);
    pix("restart_pix", 330, 350, 24'hFFD000);
    flap_pulse();
    frame();
    model_tick(1);
    check("refly_y", 32'(bird_y), 332);
    check_phys("refly");
    flap_pulse();
    rst = 1;
    step();
    rst = 0;
    exp_state = IDLE; exp_pos = 344; exp_vel = 0;
    check("midrst_state", 32'(state), 32'(IDLE));
    check("midrst_y", 32'(bird_y), 344);
    frame();
    check("midrst_frame_state", 32'(state), 32'(IDLE));
    check("midrst_frame_y", 32'(bird_y), 344);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bird_renderer.md
# bird_renderer

Per-pixel renderer and once-per-frame bird physics for the flappy bird display path. Consumes the raster position and sync stream from `pixel_iterator`, updates bird position and velocity once per frame, and emits RGB plus matching delayed `hs`/`vs`/`de` toward `dvi_tx`. Replaces the test-pattern source when the game is selected.

## Interface
- `HOR_ACTIVE_PIXELS`, 1280: active width. `X_WIDTH = $clog2` of it.
- `VER_ACTIVE_PIXELS`, 720: active height. `Y_WIDTH = $clog2` of it.
- `BIRD_X`, 320: left column of bird square.
- `BIRD_SIZE`, 32: bird square edge in pixels.
- `GRAVITY`, 1: velocity increment per frame.
- `FLAP_VELOCITY`, -12: signed velocity loaded on flap.
- `MAX_FALL_VELOCITY`, 16: positive velocity ceiling.
- `clk_rgb`  in  1: pixel clock, the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `flap`  in  1: raw button level, asynchronous, active-high.
- `x`  in  X_WIDTH: raster column, valid when `de_in`.
- `y`  in  Y_WIDTH: raster row, valid when `de_in`.
- `hs_in`, `vs_in`, `de_in`  in  1 each: syncs and data enable, active-high.
- `r`, `g`, `b`  out  8 each: pixel colour.
- `hs_out`, `vs_out`, `de_out`  out  1 each: inputs delayed to align with RGB.
- `state`  out  2: game state (`bird_pkg::state_t`).
- `bird_y`  out  Y_WIDTH: current bird top row.

## Operation
- `flap`: 2-flop synchroniser, then rising-edge detect -> `flap_edge`. Edge sets `flap_pending`, which the next frame tick clears.
- Frame tick: one-cycle pulse on the rising edge of `vs_in`. Flap at tick = `flap_pending | flap_edge`. A flap edge coinciding with the tick is consumed by that tick.
- States:
  - IDLE: bird at `Y_CENTER = (VER_ACTIVE_PIXELS-BIRD_SIZE)/2`, vel 0. On a tick with flap -> FLYING, and the flap update is applied on that same tick.
  - FLYING: each tick, vel' = flap ? FLAP_VELOCITY : min(vel+GRAVITY, MAX_FALL_VELOCITY); pos' = pos + vel'.
    - pos' < 0: pos = 0, -> DEAD.
    - pos' > `Y_MAX = VER_ACTIVE_PIXELS-BIRD_SIZE`: pos = Y_MAX, -> DEAD.
    - Landing exactly on 0 or Y_MAX stays FLYING.
  - DEAD: pos and vel frozen. Tick with flap -> IDLE; pos = Y_CENTER, vel = 0.
- Width rules:
  - Velocity is signed 8 bit.
  - Position math is signed Y_WIDTH+2 bits, so there is no wrap before clamping.
  - `bird_y` is the unsigned low Y_WIDTH bits of the clamped position.
- Pixel stage 1 registers `inside = de_in && BIRD_X <= x < BIRD_X+BIRD_SIZE && bird_y <= y < bird_y+BIRD_SIZE`, plus `de`, `hs`, `vs`.
- Pixel stage 2 registers the colour:
  - `de` low: 000000.
  - Inside, state not DEAD: BIRD_COLOR FFD000.
  - Inside, DEAD: DEAD_COLOR FF0000.
  - Otherwise: SKY_COLOR 4EC0CA.
- `bird_y` changes only on tick cycles. Tick falls during vertical sync, so no frame tears.

## Timing
- Reset values:
  - `r`/`g`/`b` = 0, `hs_out`/`vs_out`/`de_out` = 0.
  - `state` = IDLE, `bird_y` = Y_CENTER, vel = 0.
  - Synchroniser flops, `flap_pending` and previous `vs` = 0.
- Pixel latency is exactly 2 cycles from `x`/`y`/`*_in` to `r`/`g`/`b`/`*_out`, constant, no stalls.
- Physics: `state`, `bird_y` and vel update on the clock edge ending the tick cycle. Visible from the first stage-1 compare after that edge.
- Flap latency: 2 synchroniser cycles + 1 edge cycle, then applied at the next tick.
- Reset asserted mid-frame: all state returns to reset values on the next edge, and pending flap is discarded. The output stream is zeros for 2 cycles after release.
- Held `flap` generates one edge only.

## Structure
- `bird_pkg`:
  - `state_t` enum {IDLE, FLYING, DEAD}.
  - 24-bit colour constants BIRD_COLOR, DEAD_COLOR, SKY_COLOR.
  - Velocity width localparam.
- Sub-module `bird_physics`: synchroniser, edge detect, tick generation, state machine, position/velocity registers. Outputs `state`, `bird_y`.
- `bird_renderer` holds the 2-stage pixel pipeline and instantiates `bird_physics`.

## Test plan
- Reset: assert `rst` 3 cycles with random inputs -> all RGB/sync outputs 0, `state` IDLE, `bird_y` 344.
- Latency/colour: IDLE, drive `de_in`=1, x=330, y=350 -> 2 cycles later RGB FFD000. Drive x=100 -> 4EC0CA. Drive `de_in`=0 -> 000000. `hs_out`/`vs_out` equal inputs delayed by 2.
- Flap start: pulse `flap` 5 cycles, then one frame -> FLYING, `bird_y` 332. With no further flap, following ticks -> 321, 311, 302.
- Coincident flap and tick: `flap` edge on the tick cycle -> applied on that tick. Second edge before the next tick -> exactly one further flap.
- Floor death: no flaps until the velocity cap is reached -> vel stays 16. First overshoot -> `bird_y` 688, DEAD; bird pixels FF0000; `bird_y` frozen over 3 more frames.
- Restart: flap in DEAD, next tick -> IDLE, `bird_y` 344. Repeat with `rst` pulsed mid-frame -> IDLE immediately, pending flap ignored.
